// File: rtl/punit_ctrl_seq.sv
// Control sequencer for the processing unit: fetch over stb/ack, decode ALU R/I instructions, drive datapath controls.
// Optional fetch-timeout error state is enabled by defining PUNIT_TIMEOUT_EN.
//
// state     | meaning
// FETCH     | 000 request instruction at PC, wait for ack
// DECODE    | 001 controls valid from latched IR, illegal check
// EXECUTE   | 010 ALU operates, controls held
// WRITEBACK | 100 one register-file write strobe, PC advances
// ERROR     | 111 fetch timed out, everything quiet until reset
module punit_ctrl_seq #(
    parameter int                ADDR_W      = 12,
    parameter int                REG_AW      = 3,
    parameter int                IMM_W       = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                TIMEOUT_CYC = 16,
    localparam int               INST_W      = 4 + 2*REG_AW + IMM_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clkEn_i,
    output logic [ADDR_W-1:0] inst_adr_o,
    output logic              inst_stb_o,
    input  logic [INST_W-1:0] inst_dat_i,
    input  logic              inst_ack_i,
    output logic [1:0]        RegMux_c_o,
    output logic              RegWrt_c_o,
    output logic              op2_c_o,
    output logic [3:0]        ALUOp_c_o,
    output logic [REG_AW-1:0] rd_o,
    output logic [REG_AW-1:0] rs_o,
    output logic [REG_AW-1:0] rs2_o,
    output logic [IMM_W-1:0]  immed_o,
    output logic [2:0]        state_o,
    output logic              illegal_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'b000,
        S_DECODE    = 3'b001,
        S_EXECUTE   = 3'b010,
        S_WRITEBACK = 3'b100,
        S_ERROR     = 3'b111
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;

    logic [3:0] op_in;
    logic [2:0] func_in;
    logic       rtype_in;
    logic       legal_in;

    // Decode straight off the bus so controls are registered on the same edge that latches the IR.
    assign op_in    = inst_dat_i[INST_W-1 -: 4];
    assign func_in  = inst_dat_i[2:0];
    assign rtype_in = (op_in == 4'b1110);
    assign legal_in = (op_in[3:2] == 2'b00) || (rtype_in && !func_in[2]);

`ifdef PUNIT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            RegWrt_c_o <= 1'b0;
            op2_c_o    <= 1'b0;
            ALUOp_c_o  <= 4'b0000;
            rd_o       <= '0;
            rs_o       <= '0;
            rs2_o      <= '0;
            immed_o    <= '0;
            illegal_o  <= 1'b0;
`ifdef PUNIT_TIMEOUT_EN
            tmo_cnt    <= TMO_LOAD;
`endif
        end else if (clkEn_i) begin
            case (state)
                S_FETCH: begin
                    if (inst_ack_i) begin
                        state     <= S_DECODE;
                        rd_o      <= inst_dat_i[INST_W-5 -: REG_AW];
                        rs_o      <= inst_dat_i[INST_W-5-REG_AW -: REG_AW];
                        rs2_o     <= inst_dat_i[IMM_W-1 -: REG_AW];
                        immed_o   <= inst_dat_i[IMM_W-1:0];
                        illegal_o <= !legal_in;
                        op2_c_o   <= legal_in && rtype_in;
                        if (!legal_in)
                            ALUOp_c_o <= 4'b0000;
                        else if (rtype_in)
                            ALUOp_c_o <= {1'b0, func_in};
                        else
                            ALUOp_c_o <= op_in;
`ifdef PUNIT_TIMEOUT_EN
                        tmo_cnt   <= TMO_LOAD;
                    end else if (tmo_cnt == '0) begin
                        state     <= S_ERROR;
                    end else begin
                        tmo_cnt   <= tmo_cnt - 1'b1;
`endif
                    end
                end
                S_DECODE: begin
                    illegal_o <= 1'b0;
                    if (illegal_o) begin
                        // Illegal word is skipped: no execute/writeback, move on to the next address.
                        state     <= S_FETCH;
                        pc        <= pc + 1'b1;
                        op2_c_o   <= 1'b0;
                        ALUOp_c_o <= 4'b0000;
                        rd_o      <= '0;
                        rs_o      <= '0;
                        rs2_o     <= '0;
                        immed_o   <= '0;
                    end else begin
                        state     <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    state      <= S_WRITEBACK;
                    RegWrt_c_o <= 1'b1;
                end
                S_WRITEBACK: begin
                    state      <= S_FETCH;
                    pc         <= pc + 1'b1;
                    RegWrt_c_o <= 1'b0;
                    op2_c_o    <= 1'b0;
                    ALUOp_c_o  <= 4'b0000;
                    rd_o       <= '0;
                    rs_o       <= '0;
                    rs2_o      <= '0;
                    immed_o    <= '0;
                end
                S_ERROR: begin
                    state <= S_ERROR;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    assign inst_adr_o = pc;
    assign inst_stb_o = (state == S_FETCH);
    assign state_o    = state;
    assign RegMux_c_o = 2'b00;

`ifdef PUNIT_TIMEOUT_EN
    assign err_o = (state == S_ERROR);
`else
    assign err_o = 1'b0;
`endif

endmodule
